dac_scheduler: RTL and testbench

Two-channel scheduler for the serial audio DAC. Left and right sample sources strobe 12-bit two's-complement samples into per-channel holding registers. The block arbitrates between pending channels round-robin and builds a 32-bit write-and-update frame (offset-binary data, per-channel address). It then shifts the frame out MSB-first under an active-low sync, so one DAC serial port serves both audio channels.

---
 rtl/dac_scheduler_if.sv | 24 ++
 rtl/dac_scheduler.sv | 177 +++++++++++++++++
 tb/tb_dac_scheduler.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dac_scheduler_if.sv
// Sample-source and serial-DAC signal bundle for dac_scheduler.
// The slave modport is the scheduler side. The master modport is the source/DAC side.
interface dac_scheduler_if;
    logic        l_valid;
    logic [11:0] l_data;
    logic        r_valid;
    logic [11:0] r_data;
    logic        l_full;
    logic        r_full;
    logic [1:0]  ovr;
    logic        busy;
    logic        dout;
    logic        sync;

    modport slave (
        input  l_valid, l_data, r_valid, r_data,
        output l_full, r_full, ovr, busy, dout, sync
    );

    modport master (
        output l_valid, l_data, r_valid, r_data,
        input  l_full, r_full, ovr, busy, dout, sync
    );
endinterface

// File: rtl/dac_scheduler.sv
// Two-channel round-robin scheduler that serialises 12-bit audio samples into
// 32-bit offset-binary DAC frames, shifted out MSB-first under active-low sync.
module dac_scheduler #(
    parameter int         GAP    = 2,
    parameter logic [3:0] CMD    = 4'b0011,
    parameter logic [3:0] ADDR_L = 4'b0000,
    parameter logic [3:0] ADDR_R = 4'b0001
) (
    input  logic           clk,
    input  logic           rst,
    dac_scheduler_if.slave bus
);
    localparam logic [3:0] GAP_W = 4'(GAP);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_GAP = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [31:0] frame_q, frame_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic [3:0]  gap_q, gap_d;
    logic        sync_q, sync_d;
    logic        last_r_q, last_r_d;   // 1: right channel was served last
    logic        l_full_q, l_full_d;
    logic        r_full_q, r_full_d;
    logic [11:0] l_data_q, l_data_d;
    logic [11:0] r_data_q, r_data_d;
    logic [1:0]  ovr_q, ovr_d;
    logic        any_s, sel_r_s, load_l_s, load_r_s;
    logic [11:0] data_off_s;

    // Arbitration: a lone pending channel wins, a tie goes to the one not served last
    assign any_s      = l_full_q | r_full_q;
    assign sel_r_s    = r_full_q & (~l_full_q | ~last_r_q);
    assign data_off_s = (sel_r_s ? r_data_q : l_data_q) + 12'h800;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and holding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q  <= 32'h0000_0000;
            bitcnt_q <= 5'd0;
            gap_q    <= 4'd0;
            sync_q   <= 1'b1;
            last_r_q <= 1'b1;
            l_full_q <= 1'b0;
            r_full_q <= 1'b0;
            l_data_q <= 12'h000;
            r_data_q <= 12'h000;
            ovr_q    <= 2'b00;
        end else begin
            frame_q  <= frame_d;
            bitcnt_q <= bitcnt_d;
            gap_q    <= gap_d;
            sync_q   <= sync_d;
            last_r_q <= last_r_d;
            l_full_q <= l_full_d;
            r_full_q <= r_full_d;
            l_data_q <= l_data_d;
            r_data_q <= r_data_d;
            ovr_q    <= ovr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_s) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bitcnt_q == 5'd31) begin
                    state_d = (GAP_W == 4'd0) ? ST_IDLE : ST_GAP;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_GAP: begin
                if (gap_q <= 4'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-state frame load, shifting, sync and gap counting
    always_comb begin
        frame_d  = frame_q;
        bitcnt_d = bitcnt_q;
        gap_d    = gap_q;
        sync_d   = sync_q;
        last_r_d = last_r_q;
        load_l_s = 1'b0;
        load_r_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_s) begin
                    frame_d  = {4'b0000, CMD, (sel_r_s ? ADDR_R : ADDR_L), data_off_s, 8'h00};
                    bitcnt_d = 5'd0;
                    sync_d   = 1'b0;
                    last_r_d = sel_r_s;
                    load_l_s = ~sel_r_s;
                    load_r_s = sel_r_s;
                end else begin
                    sync_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                frame_d  = {frame_q[30:0], 1'b0};
                bitcnt_d = bitcnt_q + 5'd1;
                if (bitcnt_q == 5'd31) begin
                    sync_d = 1'b1;
                    gap_d  = GAP_W;
                end else begin
                    sync_d = 1'b0;
                end
            end
            ST_GAP: begin
                gap_d  = gap_q - 4'd1;
                sync_d = 1'b1;
            end
            default: begin
                frame_d = 32'h0000_0000;
                sync_d  = 1'b1;
            end
        endcase
    end

    // Holding registers: a strobe on the load edge refills without counting as overrun
    always_comb begin
        l_full_d = l_full_q;
        r_full_d = r_full_q;
        l_data_d = l_data_q;
        r_data_d = r_data_q;
        ovr_d    = ovr_q;
        if (bus.l_valid) begin
            l_full_d = 1'b1;
            l_data_d = bus.l_data;
            ovr_d[0] = ovr_q[0] | (l_full_q & ~load_l_s);
        end else if (load_l_s) begin
            l_full_d = 1'b0;
        end else begin
            l_full_d = l_full_q;
        end
        if (bus.r_valid) begin
            r_full_d = 1'b1;
            r_data_d = bus.r_data;
            ovr_d[1] = ovr_q[1] | (r_full_q & ~load_r_s);
        end else if (load_r_s) begin
            r_full_d = 1'b0;
        end else begin
            r_full_d = r_full_q;
        end
    end

    assign bus.l_full = l_full_q;
    assign bus.r_full = r_full_q;
    assign bus.ovr    = ovr_q;
    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.dout   = frame_q[31];
    assign bus.sync   = sync_q;
endmodule

// File: tb/tb_dac_scheduler.sv
// Directed and random bench for dac_scheduler. A cycle-count reference model
// predicts every output each cycle, and the captured serial words are compared to fixed values.
module tb_dac_scheduler;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst;
    dac_scheduler_if bus();

    dac_scheduler #(.GAP(GAP), .CMD(4'b0011), .ADDR_L(4'b0000), .ADDR_R(4'b0001)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state: frame timing kept as cycle numbers
    bit          m_lf, m_rf, m_last_r;
    logic [11:0] m_ld, m_rd;
    logic [1:0]  m_ovr;
    logic [31:0] m_word;
    int          m_start = -1000;
    int          m_free  = 0;

    // serial monitor
    logic [31:0] shreg = 32'h0;
    int          nb = 0;
    int          hi_run = 0;
    logic        prev_sync = 1'b1;
    logic [31:0] words[$];
    int          starts[$];
    int          hi_runs[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit ld_l, ld_r, pick_r;
        int unsigned d;
        ld_l = 1'b0;
        ld_r = 1'b0;
        if (rst) begin
            m_lf = 1'b0; m_rf = 1'b0; m_ovr = 2'b00; m_last_r = 1'b1;
            m_start = -1000; m_free = cyc + 1;
        end else begin
            if (cyc >= m_free && (m_lf || m_rf)) begin
                pick_r = (m_lf && m_rf) ? !m_last_r : m_rf;
                d = pick_r ? m_rd : m_ld;
                m_word = (32'd3 << 24) | ((pick_r ? 32'd1 : 32'd0) << 20) | (((d + 2048) % 4096) << 8);
                m_start = cyc;
                m_free = cyc + 33 + GAP;
                m_last_r = pick_r;
                ld_l = !pick_r;
                ld_r = pick_r;
            end
            if (bus.l_valid) begin
                if (m_lf && !ld_l) m_ovr[0] = 1'b1;
                m_lf = 1'b1; m_ld = bus.l_data;
            end else if (ld_l) begin
                m_lf = 1'b0;
            end
            if (bus.r_valid) begin
                if (m_rf && !ld_r) m_ovr[1] = 1'b1;
                m_rf = 1'b1; m_rd = bus.r_data;
            end else if (ld_r) begin
                m_rf = 1'b0;
            end
        end
    endtask

    task automatic step();
        bit   low;
        logic exp_dout;
        @(posedge clk);
        model_edge();
        #1;
        low = (cyc >= m_start) && (cyc <= m_start + 31);
        exp_dout = low ? m_word[31 - (cyc - m_start)] : 1'b0;
        chk("sync",   {31'd0, bus.sync},   {31'd0, !low});
        chk("dout",   {31'd0, bus.dout},   {31'd0, exp_dout});
        chk("busy",   {31'd0, bus.busy},   {31'd0, (cyc >= m_start) && (cyc <= m_free - 2)});
        chk("l_full", {31'd0, bus.l_full}, {31'd0, m_lf});
        chk("r_full", {31'd0, bus.r_full}, {31'd0, m_rf});
        chk("ovr",    {30'd0, bus.ovr},    {30'd0, m_ovr});
        if (bus.sync === 1'b0) begin
            if (prev_sync === 1'b1) begin
                starts.push_back(cyc);
                hi_runs.push_back(hi_run);
            end
            hi_run = 0;
            shreg = {shreg[30:0], bus.dout};
            nb++;
            if (nb == 32) begin
                words.push_back(shreg);
                nb = 0;
            end
        end else begin
            hi_run++;
            nb = 0;
        end
        prev_sync = bus.sync;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic strobe(input bit l, input logic [11:0] ld, input bit r, input logic [11:0] rd);
        bus.l_valid = l; bus.l_data = ld;
        bus.r_valid = r; bus.r_data = rd;
        step();
        bus.l_valid = 1'b0;
        bus.r_valid = 1'b0;
    endtask

    task automatic clr();
        words.delete();
        starts.delete();
        hi_runs.delete();
    endtask

    initial begin
        rst = 1'b1;
        bus.l_valid = 1'b0; bus.l_data = 12'h000;
        bus.r_valid = 1'b0; bus.r_data = 12'h000;
        idle(3);
        rst = 1'b0;
        chk("rst_sync", {31'd0, bus.sync}, 32'd1);
        chk("rst_dout", {31'd0, bus.dout}, 32'd0);
        chk("rst_ovr",  {30'd0, bus.ovr},  32'd0);

        // single left sample of zero
        clr();
        strobe(1'b1, 12'h000, 1'b0, 12'h000);
        idle(45);
        chk("t1_count", words.size(), 32'd1);
        chk("t1_word",  words[0], 32'h0308_0000);
        chk("t1_ovr",   {30'd0, bus.ovr}, 32'd0);

        // two right samples, second arriving mid-frame
        clr();
        strobe(1'b0, 12'h000, 1'b1, 12'h7FF);
        idle(5);
        strobe(1'b0, 12'h000, 1'b1, 12'hFFF);
        idle(90);
        chk("t2_count", words.size(), 32'd2);
        chk("t2_w0",    words[0], 32'h031F_FF00);
        chk("t2_w1",    words[1], 32'h0317_FF00);
        chk("t2_hi",    hi_runs[1], 32'(GAP + 1));

        // simultaneous strobes, twice
        clr();
        strobe(1'b1, 12'h001, 1'b1, 12'h002);
        idle(90);
        chk("t3_w0",  words[0], 32'h0308_0100);
        chk("t3_w1",  words[1], 32'h0318_0200);
        chk("t3_gap", starts[1] - starts[0], 32'd35);
        clr();
        strobe(1'b1, 12'h003, 1'b1, 12'h004);
        idle(90);
        chk("t3b_w0", words[0], 32'h0308_0300);
        chk("t3b_w1", words[1], 32'h0318_0400);

        // left overrun during a right frame
        clr();
        strobe(1'b0, 12'h000, 1'b1, 12'h000);
        idle(3);
        strobe(1'b1, 12'h100, 1'b0, 12'h000);
        idle(3);
        strobe(1'b1, 12'h200, 1'b0, 12'h000);
        idle(100);
        chk("t4_count", words.size(), 32'd2);
        chk("t4_w0",    words[0], 32'h0318_0000);
        chk("t4_w1",    words[1], 32'h030A_0000);
        chk("t4_ovr",   {30'd0, bus.ovr}, 32'd1);

        // reset while bit 10 is on the line
        clr();
        strobe(1'b1, 12'h123, 1'b0, 12'h000);
        idle(11);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_sync",  {31'd0, bus.sync},   32'd1);
        chk("t5_dout",  {31'd0, bus.dout},   32'd0);
        chk("t5_busy",  {31'd0, bus.busy},   32'd0);
        chk("t5_lfull", {31'd0, bus.l_full}, 32'd0);
        chk("t5_ovr",   {30'd0, bus.ovr},    32'd0);
        idle(40);
        chk("t5_none",  words.size(), 32'd0);

        // strobe on the left load edge
        clr();
        strobe(1'b1, 12'h010, 1'b0, 12'h000);
        strobe(1'b1, 12'h020, 1'b0, 12'h000);
        idle(90);
        chk("t6_count", words.size(), 32'd2);
        chk("t6_w0",    words[0], 32'h0308_1000);
        chk("t6_w1",    words[1], 32'h0308_2000);
        chk("t6_ovr",   {30'd0, bus.ovr}, 32'd0);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 1499) == 0);
            bus.l_valid = ($urandom_range(0, 39) == 0);
            bus.l_data  = 12'($urandom);
            bus.r_valid = ($urandom_range(0, 39) == 0);
            bus.r_data  = 12'($urandom);
            step();
        end
        rst = 1'b0;
        bus.l_valid = 1'b0;
        bus.r_valid = 1'b0;
        idle(80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
